// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF evaluation controller.
// Holds the FSM state encoding, the operating mode and the eval-count sizing.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWait     = 3'd2,
    StAccum    = 3'd3,
    StDone     = 3'd4,
    StRngIssue = 3'd5,
    StRngWait  = 3'd6
  } puf_ctrl_state_e;

  typedef enum logic {
    PufAuth = 1'b0,
    PufRng  = 1'b1
  } puf_mode_e;

  localparam int unsigned MaxEval  = 15;
  // Wide enough that the RNG challenge tweak cycles through many values before wrapping.
  localparam int unsigned EvalCntW = 8;

  function automatic logic is_rng_state(input puf_ctrl_state_e st);
    return (st == StRngIssue) || (st == StRngWait);
  endfunction

endpackage

// File: rtl/puf_rng_fifo.sv
// Synchronous FIFO buffering folded RNG words for the entropy source.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module puf_rng_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r;
  logic [PtrW-1:0]  rd_ptr_r;
  logic [CntW-1:0]  count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Qualify push and pop against the current occupancy.
  always_comb begin
    pop_ok_s  = pop_i && (count_r != '0);
    push_ok_s = push_i && ((count_r != CntW'(Depth)) || pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata_i;
        wr_ptr_r        <= wr_ptr_r + PtrW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      count_r <= count_r + CntW'(push_ok_s) - CntW'(pop_ok_s);
    end
  end

  assign rdata_o = mem_r[rd_ptr_r];
  assign full_o  = (count_r == CntW'(Depth));
  assign empty_o = (count_r == '0);
  assign count_o = count_r;

endmodule

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation controller: majority-vote authentication and RNG word harvesting
// from a raw PUF core, with a bounded wait on the core handshake.
module puf_eval_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned ChalW      = 128,
  parameter int unsigned RespW      = 256,
  parameter int unsigned NumEval    = 5,
  parameter int unsigned RngW       = 4,
  parameter int unsigned RngDepth   = 8,
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic             start_i,
  input  logic [ChalW-1:0] challenge_i,
  output logic             busy_o,
  output logic             resp_valid_o,
  output logic [RespW-1:0] resp_o,
  output logic [RespW-1:0] resp_unstable_o,
  output logic             err_timeout_o,
  output logic             core_req_o,
  output logic [ChalW-1:0] core_chal_o,
  input  logic             core_ack_i,
  input  logic [RespW-1:0] core_resp_i,
  output logic             rng_mode_o,
  output logic             rng_valid_o,
  output logic [RngW-1:0]  rng_o,
  input  logic             rng_req_i
);

  localparam int unsigned CntW     = $clog2(NumEval+1);
  localparam int unsigned TmoW     = $clog2(TimeoutCyc);
  localparam int unsigned NumSlice = RespW / RngW;
  localparam int unsigned FifoCntW = $clog2(RngDepth+1);

  puf_ctrl_state_e       state_r, state_s;
  puf_mode_e             mode_r;
  logic [ChalW-1:0]      chal_r;
  logic [EvalCntW-1:0]   eval_cnt_r;
  logic [TmoW-1:0]       tmo_cnt_r;
  logic [CntW-1:0]       vote_cnt_r [RespW];
  logic                  core_req_r;
  logic [ChalW-1:0]      core_chal_r;
  logic [RespW-1:0]      resp_r, unstable_r;
  logic [RespW-1:0]      resp_s, unstable_s;
  logic                  resp_valid_r, err_r, busy_r, rng_mode_r;
  logic                  accept_s, issue_s, acc_s, push_s, timeout_s, abort_s, done_s;
  logic                  flush_s, pop_s;
  logic [RngW-1:0]       word_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [FifoCntW-1:0]   fifo_cnt_s;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= StIdle;
    else         state_r <= state_s;
  end

  // Next-state logic and datapath strobes; dropping enable overrides everything.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    issue_s   = 1'b0;
    acc_s     = 1'b0;
    push_s    = 1'b0;
    timeout_s = 1'b0;
    abort_s   = 1'b0;
    done_s    = 1'b0;
    if ((state_r != StIdle) && !enable_i) begin
      abort_s = 1'b1;
      state_s = StIdle;
    end else begin
      case (state_r)
        StIdle: begin
          if (start_i && enable_i) begin
            accept_s = 1'b1;
            state_s  = (puf_mode_e'(mode_i) == PufRng) ? StRngIssue : StIssue;
          end else begin
            state_s = StIdle;
          end
        end
        StIssue: begin
          issue_s = 1'b1;
          state_s = StWait;
        end
        StWait: begin
          if (core_ack_i) begin
            acc_s   = 1'b1;
            state_s = StAccum;
          end else if (tmo_cnt_r == TmoW'(TimeoutCyc-1)) begin
            timeout_s = 1'b1;
            state_s   = StIdle;
          end else begin
            state_s = StWait;
          end
        end
        StAccum: begin
          state_s = (eval_cnt_r == EvalCntW'(NumEval)) ? StDone : StIssue;
        end
        StDone: begin
          done_s  = 1'b1;
          state_s = StIdle;
        end
        StRngIssue: begin
          if (!fifo_full_s) begin
            issue_s = 1'b1;
            state_s = StRngWait;
          end else begin
            state_s = StRngIssue;
          end
        end
        StRngWait: begin
          if (core_ack_i) begin
            push_s  = 1'b1;
            state_s = StRngIssue;
          end else if (tmo_cnt_r == TmoW'(TimeoutCyc-1)) begin
            timeout_s = 1'b1;
            state_s   = StIdle;
          end else begin
            state_s = StRngWait;
          end
        end
        default: state_s = StIdle;
      endcase
    end
  end

  // Majority decision and unanimity check per response bit, plus the RNG fold.
  always_comb begin
    resp_s     = '0;
    unstable_s = '0;
    word_s     = '0;
    for (int i = 0; i < RespW; i++) begin
      resp_s[i]     = (vote_cnt_r[i] > CntW'(NumEval/2));
      unstable_s[i] = (vote_cnt_r[i] != '0) && (vote_cnt_r[i] != CntW'(NumEval));
    end
    for (int k = 0; k < NumSlice; k++) begin
      word_s = word_s ^ core_resp_i[k*RngW +: RngW];
    end
  end

  // Per-bit vote counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RespW; i++) vote_cnt_r[i] <= '0;
    end else if (accept_s || abort_s || timeout_s) begin
      for (int i = 0; i < RespW; i++) vote_cnt_r[i] <= '0;
    end else if (acc_s) begin
      for (int i = 0; i < RespW; i++) vote_cnt_r[i] <= vote_cnt_r[i] + CntW'(core_resp_i[i]);
    end
  end

  // Operation context, counters, core handshake and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_r       <= PufAuth;
      chal_r       <= '0;
      eval_cnt_r   <= '0;
      tmo_cnt_r    <= '0;
      core_req_r   <= 1'b0;
      core_chal_r  <= '0;
      resp_r       <= '0;
      unstable_r   <= '0;
      resp_valid_r <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      rng_mode_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        mode_r <= puf_mode_e'(mode_i);
        chal_r <= challenge_i;
      end
      if (accept_s || abort_s || timeout_s) eval_cnt_r <= '0;
      else if (acc_s || push_s)             eval_cnt_r <= eval_cnt_r + EvalCntW'(1);
      // Timeout counter only runs while parked in a wait state.
      if (((state_r == StWait) || (state_r == StRngWait)) && (state_s == state_r))
        tmo_cnt_r <= tmo_cnt_r + TmoW'(1);
      else
        tmo_cnt_r <= '0;
      if (issue_s)                                         core_req_r <= 1'b1;
      else if (acc_s || push_s || timeout_s || abort_s)    core_req_r <= 1'b0;
      if (issue_s)
        core_chal_r <= (mode_r == PufRng) ? (chal_r ^ ChalW'(eval_cnt_r)) : chal_r;
      if (accept_s) begin
        resp_valid_r <= 1'b0;
        err_r        <= 1'b0;
      end else begin
        if (done_s)    resp_valid_r <= 1'b1;
        if (timeout_s) err_r        <= 1'b1;
      end
      if (done_s) begin
        resp_r     <= resp_s;
        unstable_r <= unstable_s;
      end
      busy_r     <= (state_s != StIdle);
      rng_mode_r <= is_rng_state(state_s);
    end
  end

  assign flush_s = accept_s && (puf_mode_e'(mode_i) == PufRng);
  assign pop_s   = rng_req_i && !fifo_empty_s;

  puf_rng_fifo #(
    .Width (RngW),
    .Depth (RngDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_s),
    .push_i  (push_s),
    .wdata_i (word_s),
    .pop_i   (pop_s),
    .rdata_o (rng_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_cnt_s)
  );

  assign busy_o          = busy_r;
  assign resp_valid_o    = resp_valid_r;
  assign resp_o          = resp_r;
  assign resp_unstable_o = unstable_r;
  assign err_timeout_o   = err_r;
  assign core_req_o      = core_req_r;
  assign core_chal_o     = core_chal_r;
  assign rng_mode_o      = rng_mode_r;
  assign rng_valid_o     = (fifo_cnt_s != '0);

endmodule
